pipeline_hazard_ctrl: RTL and testbench

- Consumer of the main decoder's control outputs (MemRead, Branch/Jump resolution, Halt) in the 5-stage RISC-V pipeline.
- Turns them into pipeline steering signals: PC/IF-ID write enables, ID/EX bubble insertion, IF/ID and ID/EX flushes, and the halt-drain sequence.
- Sits beside the datapath, between the ID and EX stage registers.

---
 rtl/pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Hazard and steering control for a 5-stage RISC-V pipeline. It takes the
//   decoder's control outputs for the instructions in ID and EX and produces
//   the pipeline steering signals:
//     - load-use stall (hold PC and IF/ID, bubble into ID/EX)
//     - redirect flush (clear IF/ID and ID/EX on a taken branch/jump)
//     - halt drain (let the HALT and the instructions ahead of it retire,
//       then report halted)
//
// Parameters:
//   REG_ADDR_W   register index width
//   DRAIN_CYCLES cycles from HALT leaving ID until the pipeline is empty (>=1)
//   CNT_W        width of the optional performance counters
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   id_rs1       rs1 index of the instruction in ID
//   id_rs2       rs2 index of the instruction in ID
//   id_uses_rs2  ID instruction reads rs2
//   id_halt      ID instruction is HALT
//   ex_mem_read  EX instruction is a load
//   ex_rd        destination index of the EX instruction
//   ex_redirect  EX resolved a taken branch / JAL / JALR this cycle
//   pc_write     PC register enable
//   ifid_write   IF/ID register enable
//   idex_bubble  zero the control fields entering ID/EX
//   ifid_flush   clear IF/ID to a NOP
//   idex_flush   clear ID/EX to a NOP
//   halted       registered: pipeline fully drained after HALT
//   stall_cnt    load-use stall cycles (optional feature, else 0)
//   flush_cnt    honoured redirect events (optional feature, else 0)
//
// Optional feature macro: PIPELINE_HAZARD_CTRL_PERF_CNT_EN
//   Defined   : stall_cnt / flush_cnt are saturating counters.
//   Undefined : both ports are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs2,
   input  logic                  id_halt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_redirect,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_bubble,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  halted,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int DCNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES);
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic                halted_q;
   logic                load_use;

   // A load in EX whose destination feeds the ID instruction. x0 is never a
   // real dependency, and rs2 only matters if the instruction reads it.
   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         dcnt_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dcnt_q   <= dcnt_d;
         halted_q <= (state_d == ST_HALTED);
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         ST_RUN: begin
            // Redirect makes the ID instruction wrong-path; load-use takes
            // precedence over a HALT carrying matching (garbage) indices.
            if (!ex_redirect && !load_use && id_halt) begin
               state_d = ST_DRAIN;
               dcnt_d  = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (ex_redirect) begin
               // An older instruction redirected: the HALT was wrong-path.
               state_d = ST_RUN;
               dcnt_d  = '0;
            end else begin
               dcnt_d = dcnt_q - DRAIN_LAST;
               if (dcnt_q == DRAIN_LAST) begin
                  state_d = ST_HALTED;
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RUN;
            dcnt_d  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_RUN: begin
               if (ex_redirect) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end else if (id_halt) begin
                  // HALT itself moves into EX; fetch is frozen behind it.
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
               end
            end
            ST_DRAIN: begin
               if (ex_redirect) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            default: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end
         endcase
      end
   end

   assign halted = halted_q;

   // ------------------------------------------------- performance counters
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
   logic             stall_evt;
   logic             flush_evt;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   assign stall_evt = !reset && (state_q == ST_RUN) && !ex_redirect && load_use;
   assign flush_evt = !reset && ex_redirect &&
                      ((state_q == ST_RUN) || (state_q == ST_DRAIN));

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. A reference model tracks "how many
// cycles since a HALT was accepted" plus event counts and derives the expected
// steering outputs each cycle; a compare process checks every output on every
// falling edge. Hand-computed literal expectations pin key points of the
// directed sequence. Counters run with CNT_W=4 so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int AW    = 5;
   localparam int DRAIN = 3;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef PIPELINE_HAZARD_CTRL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs2, id_halt, ex_mem_read, ex_redirect;
   logic          pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, halted;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;
   int cycle_no = 0;
   bit cmp_en   = 1'b0;

   // model state
   int since_halt = 0;   // 0: no halt in flight, k: k-th cycle after HALT left ID
   int m_stalls   = 0;
   int m_flushes  = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_ADDR_W  (AW),
      .DRAIN_CYCLES(DRAIN),
      .CNT_W       (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_uses_rs2(id_uses_rs2),
      .id_halt    (id_halt),
      .ex_mem_read(ex_mem_read),
      .ex_rd      (ex_rd),
      .ex_redirect(ex_redirect),
      .pc_write   (pc_write),
      .ifid_write (ifid_write),
      .idex_bubble(idex_bubble),
      .ifid_flush (ifid_flush),
      .idex_flush (idex_flush),
      .halted     (halted),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle_no, act, exp);
      end
   endtask

   function automatic bit model_lu();
      return ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // model: advance one cycle
   always @(posedge clk) begin
      if (reset) begin
         since_halt <= 0;
         m_stalls   <= 0;
         m_flushes  <= 0;
      end else if (since_halt == 0) begin
         if (ex_redirect)     m_flushes  <= sat_inc(m_flushes);
         else if (model_lu()) m_stalls   <= sat_inc(m_stalls);
         else if (id_halt)    since_halt <= 1;
      end else if (since_halt <= DRAIN) begin
         if (ex_redirect) begin
            since_halt <= 0;
            m_flushes  <= sat_inc(m_flushes);
         end else begin
            since_halt <= since_halt + 1;
         end
      end
   end

   // compare process
   always @(negedge clk) begin
      if (cmp_en) begin
         bit e_pw, e_iw, e_bub, e_ff, e_xf;
         e_pw = 1; e_iw = 1; e_bub = 0; e_ff = 0; e_xf = 0;
         if (!reset) begin
            if (since_halt == 0) begin
               if (ex_redirect) begin e_ff = 1; e_xf = 1; end
               else if (model_lu()) begin e_pw = 0; e_iw = 0; e_bub = 1; end
               else if (id_halt) begin e_pw = 0; e_iw = 0; end
            end else if (since_halt <= DRAIN && ex_redirect) begin
               e_ff = 1; e_xf = 1;
            end else begin
               e_pw = 0; e_iw = 0; e_bub = 1;
            end
         end
         check("pc_write",    int'(pc_write),    int'(e_pw));
         check("ifid_write",  int'(ifid_write),  int'(e_iw));
         check("idex_bubble", int'(idex_bubble), int'(e_bub));
         check("ifid_flush",  int'(ifid_flush),  int'(e_ff));
         check("idex_flush",  int'(idex_flush),  int'(e_xf));
         check("halted",      int'(halted),      (since_halt > DRAIN) ? 1 : 0);
         check("stall_cnt",   int'(stall_cnt),   PERF ? m_stalls  : 0);
         check("flush_cnt",   int'(flush_cnt),   PERF ? m_flushes : 0);
      end
   end

   // drive one cycle of inputs just after the rising edge, settle before return
   task automatic cyc(input bit rst, input int rs1, input int rs2, input bit uses,
                      input bit halt, input bit mr, input int rd, input bit redir);
      @(posedge clk);
      #1;
      cycle_no++;
      reset       = rst;
      id_rs1      = AW'(rs1);
      id_rs2      = AW'(rs2);
      id_uses_rs2 = uses;
      id_halt     = halt;
      ex_mem_read = mr;
      ex_rd       = AW'(rd);
      ex_redirect = redir;
      $display("cycle %0d: rst=%0b rs1=%0d rs2=%0d uses=%0b halt=%0b mr=%0b rd=%0d redir=%0b",
               cycle_no, rst, rs1, rs2, uses, halt, mr, rd, redir);
      #3;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0; id_halt = 0;
      ex_mem_read = 0; ex_rd = '0; ex_redirect = 0;
      @(posedge clk);
      cmp_en = 1'b1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset_pc_write", int'(pc_write), 1);
      check("reset_bubble",   int'(idex_bubble), 0);
      idle();
      check("post_reset_halted", int'(halted), 0);

      // load-use on rs1, then the bubble clears the load
      cyc(0, 5, 0, 0, 0, 1, 5, 0);
      check("lu_pc_write", int'(pc_write), 0);
      check("lu_bubble",   int'(idex_bubble), 1);
      idle();
      check("lu_release_pc_write", int'(pc_write), 1);
      check("lu_stall_cnt", int'(stall_cnt), PERF ? 1 : 0);

      // rs2 filtering and x0
      cyc(0, 3, 7, 0, 0, 1, 7, 0);
      check("rs2_unused_pc_write", int'(pc_write), 1);
      cyc(0, 3, 7, 1, 0, 1, 7, 0);
      check("rs2_used_pc_write", int'(pc_write), 0);
      cyc(0, 0, 0, 1, 0, 1, 0, 0);
      check("x0_pc_write", int'(pc_write), 1);

      // redirect beats load-use
      cyc(0, 5, 0, 0, 0, 1, 5, 1);
      check("redir_ifid_flush", int'(ifid_flush), 1);
      check("redir_idex_flush", int'(idex_flush), 1);
      check("redir_bubble",     int'(idex_bubble), 0);
      idle();
      check("redir_flush_cnt", int'(flush_cnt), PERF ? 1 : 0);

      // halt drain, then held halted with random inputs, then reset
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      check("halt_pc_write", int'(pc_write), 0);
      check("halt_bubble",   int'(idex_bubble), 0);
      for (int i = 0; i < DRAIN; i++) begin
         cyc(0, 0, 0, 0, 1, 0, 0, 0);
         check("drain_bubble", int'(idex_bubble), 1);
         check("drain_halted", int'(halted), 0);
      end
      for (int i = 0; i < 20; i++) begin
         cyc(0, $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, 31), 1'($urandom));
         check("held_halted",   int'(halted), 1);
         check("held_pc_write", int'(pc_write), 0);
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset_in_halted_pc_write", int'(pc_write), 1);
      idle();
      check("after_reset_halted", int'(halted), 0);
      check("after_reset_pc_write", int'(pc_write), 1);

      // wrong-path halt: redirect in the first drain cycle
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("wp_ifid_flush", int'(ifid_flush), 1);
      check("wp_pc_write",   int'(pc_write), 1);
      idle();
      check("wp_run_pc_write", int'(pc_write), 1);
      for (int i = 0; i < 4; i++) idle();
      check("wp_halted", int'(halted), 0);

      // redirect honoured in the last drain cycle
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      idle();
      idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      check("late_redir_idex_flush", int'(idex_flush), 1);
      idle();
      check("late_redir_halted",   int'(halted), 0);
      check("late_redir_pc_write", int'(pc_write), 1);

      // halt with matching indices: load-use wins, no drain
      cyc(0, 4, 0, 0, 1, 1, 4, 0);
      check("halt_lu_bubble", int'(idex_bubble), 1);
      idle();
      check("halt_lu_pc_write", int'(pc_write), 1);

      // saturation: 17 stall cycles
      for (int i = 0; i < 17; i++) cyc(0, 9, 0, 0, 0, 1, 9, 0);
      idle();
      check("sat_stall_cnt", int'(stall_cnt), PERF ? 15 : 0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
